systolic_array_stream: RTL and testbench

Parametrised, streaming successor to the fixed 4x4 tile engine. Computes C = A·B for a ROWS×COLS output tile with a runtime K depth. A columns and B rows arrive one k-slice per handshake, and skewing is done internally. Supports accumulation across jobs, then requantises (arithmetic shift + saturate) and drains results row by row under backpressure. Sits between the tile-fetch DMA and the output writeback in the CNN datapath.

---
 rtl/sa_pkg.sv | 37 +++
 rtl/sa_pe_mac.sv | 60 ++++++
 rtl/systolic_array_stream.sv | 213 +++++++++++++++++++++
 tb/tb_systolic_array_stream.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and the drain-side requantiser for systolic_array_stream.
// sat_shift works on a wide signed value so any ACCW/OW up to SAT_W is handled.
package sa_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} sa_state_e;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    sat;
  } sat_res_t;

  // Floor shift, then clamp to the signed ow-bit range.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int shift,
                                         input int ow);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    shifted   = acc >>> shift;
    hi        = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo        = -(64'sd1 <<< (ow - 1));
    res.sat   = 1'b0;
    res.value = shifted;
    if (shifted > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (shifted < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_pe_mac.sv
// One processing element: signed MAC into a wrapping accumulator, with
// registered A (rightward) and B (downward) forwarding under a global enable.
module sa_pe_mac
  import sa_pkg::*;
#(
  parameter int AW   = 8,
  parameter int BW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic signed [AW-1:0]   a_in,
  input  logic signed [BW-1:0]   b_in,
  output logic signed [AW-1:0]   a_out,
  output logic signed [BW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);

  logic signed [AW-1:0]    a_q, a_d;
  logic signed [BW-1:0]    b_q, b_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [AW+BW-1:0] prod;

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path can infer a latch.
    prod  = (AW+BW)'(a_in) * (AW+BW)'(b_in);
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q + ACCW'(prod);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_stream.sv
// Output-stationary ROWSxCOLS systolic array: streams k-slices through
// internal skew lines, flushes, then drains requantised rows under backpressure.
module systolic_array_stream
  import sa_pkg::*;
#(
  parameter  int AW   = 8,
  parameter  int BW   = 8,
  parameter  int ACCW = 32,
  parameter  int OW   = 8,
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  parameter  int KW   = 16,
  localparam int SHW  = $clog2(ACCW),
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [KW-1:0]        cfg_k_len,
  input  logic                 cfg_accumulate,
  input  logic [SHW-1:0]       cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*AW-1:0]   in_a,
  input  logic [COLS*BW-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*OW-1:0]   out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sat_flag
);

  localparam int FLUSH_CYC = ROWS + COLS - 2;
  localparam int FCW       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  sa_state_e      state_q, state_d;
  logic [KW-1:0]  k_len_q, k_len_d, k_cnt_q, k_cnt_d;
  logic [SHW-1:0] shift_q, shift_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic           sat_q, sat_d;
  logic           clr_acc, adv, drain_sat;

  logic signed [AW-1:0]   a_w   [ROWS][COLS+1];
  logic signed [BW-1:0]   b_w   [ROWS+1][COLS];
  logic signed [ACCW-1:0] acc_w [ROWS][COLS];
  logic [ROWS*AW+COLS*BW-1:0] unused_edges;
  sat_res_t               sat_res [COLS];

  // One step of the array per accepted slice, or every cycle while flushing.
  assign adv = ((state_q == STREAM) && in_valid) || (state_q == FLUSH);

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [AW-1:0] src;
    assign src = (state_q == STREAM) ? in_a[r*AW +: AW] : '0;
    if (r == 0) begin : g_direct
      assign a_w[r][0] = src;
    end else begin : g_line
      logic signed [AW-1:0] sr_q [r];
      logic signed [AW-1:0] sr_d [r];
      always_comb begin
        sr_d = sr_q;
        if (adv) begin
          sr_d[0] = src;
          for (int i = 1; i < r; i++) sr_d[i] = sr_q[i-1];
        end
      end
      // NOTE: skew lines are reset too; a stale entry would leak into the first job's sums.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < r; i++) sr_q[i] <= '0;
        else        sr_q <= sr_d;
      end
      assign a_w[r][0] = sr_q[r-1];
    end
    assign unused_edges[r*AW +: AW] = a_w[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [BW-1:0] src;
    assign src = (state_q == STREAM) ? in_b[c*BW +: BW] : '0;
    if (c == 0) begin : g_direct
      assign b_w[0][c] = src;
    end else begin : g_line
      logic signed [BW-1:0] sr_q [c];
      logic signed [BW-1:0] sr_d [c];
      always_comb begin
        sr_d = sr_q;
        if (adv) begin
          sr_d[0] = src;
          for (int i = 1; i < c; i++) sr_d[i] = sr_q[i-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < c; i++) sr_q[i] <= '0;
        else        sr_q <= sr_d;
      end
      assign b_w[0][c] = sr_q[c-1];
    end
    assign unused_edges[ROWS*AW + c*BW +: BW] = b_w[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe_mac #(.AW(AW), .BW(BW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .clr   (clr_acc),
        .a_in  (a_w[r][c]),
        .b_in  (b_w[r][c]),
        .a_out (a_w[r][c+1]),
        .b_out (b_w[r+1][c]),
        .acc   (acc_w[r][c])
      );
    end
  end

  // Requantise the row selected by the drain counter; zero outside DRAIN.
  always_comb begin
    out_data  = '0;
    drain_sat = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      sat_res[c] = sat_shift(SAT_W'(acc_w[row_q][c]), int'(shift_q), OW);
      if (state_q == DRAIN) begin
        out_data[c*OW +: OW] = sat_res[c].value[OW-1:0];
        drain_sat            = drain_sat | sat_res[c].sat;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    k_cnt_d     = k_cnt_q;
    shift_d     = shift_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    sat_d       = sat_q;
    clr_acc     = 1'b0;
    case (state_q)
      IDLE: if (cfg_valid) begin
        k_len_d     = cfg_k_len;
        shift_d     = cfg_shift;
        clr_acc     = !cfg_accumulate;
        sat_d       = 1'b0;
        k_cnt_d     = '0;
        flush_cnt_d = '0;
        row_d       = '0;
        if (cfg_k_len != '0)     state_d = STREAM;
        else if (FLUSH_CYC == 0) state_d = DRAIN;
        else                     state_d = FLUSH;
      end
      STREAM: if (in_valid) begin
        k_cnt_d = k_cnt_q + KW'(1);
        if (k_cnt_q == k_len_q - KW'(1)) begin
          if (FLUSH_CYC == 0) state_d = DRAIN;
          else                state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FCW'(1);
        if (flush_cnt_q == FCW'(FLUSH_CYC - 1)) begin
          flush_cnt_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_sat) sat_d = 1'b1;
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      shift_q     <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      shift_q     <= shift_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      sat_q       <= sat_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == STREAM);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (row_q == RW'(ROWS - 1));
  assign out_row   = row_q;
  assign busy      = (state_q != IDLE);
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_systolic_array_stream.sv
// Self-checking bench for systolic_array_stream: constant vector table, an
// identity/latency sequence, randomized jobs against a matrix model, reset mid-flush.
module tb_systolic_array_stream;

  localparam int AW = 8, BW = 8, ACCW = 32, OW = 8, ROWS = 4, COLS = 4, KW = 16;
  localparam int SHW = $clog2(ACCW);
  localparam int RW = 2;
  localparam int MAXK = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid, cfg_ready, cfg_accumulate;
  logic [KW-1:0]        cfg_k_len;
  logic [SHW-1:0]       cfg_shift;
  logic                 in_valid, in_ready;
  logic [ROWS*AW-1:0]   in_a;
  logic [COLS*BW-1:0]   in_b;
  logic                 out_valid, out_ready, out_last, busy, sat_flag;
  logic [COLS*OW-1:0]   out_data;
  logic [RW-1:0]        out_row;

  always #5 clk = ~clk;

  systolic_array_stream #(
    .AW(AW), .BW(BW), .ACCW(ACCW), .OW(OW), .ROWS(ROWS), .COLS(COLS), .KW(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_k_len(cfg_k_len),
    .cfg_accumulate(cfg_accumulate), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
  );

  int total = 0;
  int bad   = 0;

  int ta   [ROWS][MAXK];
  int tb_m [MAXK][COLS];
  int macc [ROWS][COLS];
  int got  [ROWS][COLS];

  typedef struct {
    int k;
    bit acc;
    int sh;
    int a;
    int b;
    int exp_v;
    bit exp_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Floor division by 2^sh, then clamp to the signed 8-bit range.
  function automatic int requant(input int v, input int sh, output bit sat);
    longint d, q;
    d = longint'(1) << sh;
    q = longint'(v) / d;
    if ((longint'(v) % d != 0) && (v < 0)) q = q - 1;
    sat = 1'b0;
    if (q > 127) begin
      q   = 127;
      sat = 1'b1;
    end else if (q < -128) begin
      q   = -128;
      sat = 1'b1;
    end
    return int'(q);
  endfunction

  // C (+)= A*B as a plain matrix product; int arithmetic wraps at 32 bits.
  task automatic model_job(input int k, input bit acc);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!acc) macc[r][c] = 0;
        for (int kk = 0; kk < k; kk++) macc[r][c] += ta[r][kk] * tb_m[kk][c];
      end
  endtask

  task automatic run_job(input int k, input bit acc, input int sh,
                         input bit gaps, input bit stall, output bit sat_seen);
    logic [COLS*OW-1:0] exp_rows [ROWS];
    logic [COLS*OW-1:0] prev_data;
    logic [RW-1:0]      prev_row;
    logic               prev_last;
    bit                 exp_sat, s, have_prev, accepted;
    int                 idx, cyc, n, row;

    exp_sat = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_rows[r][c*OW +: OW] = OW'(requant(macc[r][c], sh, s));
        exp_sat = exp_sat | s;
      end

    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid      = 1'b1;
    cfg_k_len      = KW'(k);
    cfg_accumulate = acc;
    cfg_shift      = SHW'(sh);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("busy_after_cfg", busy, 1);
    check("in_ready_after_cfg", in_ready, (k > 0) ? 1 : 0);

    idx = 0;
    cyc = 0;
    while (idx < k && cyc < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      for (int r = 0; r < ROWS; r++)
        in_a[r*AW +: AW] = in_valid ? AW'(ta[r][idx]) : AW'($urandom);
      for (int c = 0; c < COLS; c++)
        in_b[c*BW +: BW] = in_valid ? BW'(tb_m[idx][c]) : BW'($urandom);
      accepted = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    if (idx < k) check("stream_timeout", idx, k);

    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_out_latency", n, ROWS + COLS - 2);

    row       = 0;
    cyc       = 0;
    have_prev = 1'b0;
    while (row < ROWS && cyc < 500) begin
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (have_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_row", out_row, prev_row);
        check("hold_last", out_last, prev_last);
      end
      have_prev = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check("row_data", out_data, exp_rows[row]);
          check("out_row", out_row, row);
          check("out_last", out_last, (row == ROWS - 1) ? 1 : 0);
          for (int c = 0; c < COLS; c++) got[row][c] = int'($signed(out_data[c*OW +: OW]));
          row++;
        end else begin
          prev_data = out_data;
          prev_row  = out_row;
          prev_last = out_last;
          have_prev = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (row < ROWS) check("drain_timeout", row, ROWS);
    check("busy_after_drain", busy, 0);
    check("cfg_ready_after_drain", cfg_ready, 1);
    check("sat_flag_model", sat_flag, exp_sat);
    sat_seen = sat_flag;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sat_seen;
    int k, acc, sh;

    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_k_len = '0; cfg_accumulate = 1'b0; cfg_shift = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity A: drained rows must equal B.
    for (int r = 0; r < ROWS; r++)
      for (int kk = 0; kk < 4; kk++) ta[r][kk] = (r == kk) ? 1 : 0;
    for (int kk = 0; kk < 4; kk++)
      for (int c = 0; c < COLS; c++) tb_m[kk][c] = kk * 4 + c;
    model_job(4, 1'b0);
    run_job(4, 1'b0, 0, 1'b0, 1'b0, sat_seen);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) check("identity", got[r][c], r * 4 + c);
    check("identity_sat", sat_seen, 0);

    vecs[0] = '{1, 1'b0, 0,    3,  -2,   -6, 1'b0};
    vecs[1] = '{4, 1'b0, 0,    1,   1,    4, 1'b0};
    vecs[2] = '{4, 1'b1, 0,    1,   1,    8, 1'b0};
    vecs[3] = '{4, 1'b0, 0,    1,   1,    4, 1'b0};
    vecs[4] = '{8, 1'b0, 4,  127, 127,  127, 1'b1};
    vecs[5] = '{8, 1'b0, 4, -128, 127, -128, 1'b1};
    vecs[6] = '{5, 1'b0, 0,    1,   1,    5, 1'b0};
    vecs[7] = '{0, 1'b1, 0,    0,   0,    5, 1'b0};
    vecs[8] = '{5, 1'b0, 1,   -1,   1,   -3, 1'b0};
    for (int i = 0; i < 9; i++) begin
      for (int kk = 0; kk < MAXK; kk++) begin
        for (int r = 0; r < ROWS; r++) ta[r][kk] = vecs[i].a;
        for (int c = 0; c < COLS; c++) tb_m[kk][c] = vecs[i].b;
      end
      model_job(vecs[i].k, vecs[i].acc);
      run_job(vecs[i].k, vecs[i].acc, vecs[i].sh, 1'b0, 1'b0, sat_seen);
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) check($sformatf("vec%0d_out", i), got[r][c], vecs[i].exp_v);
      check($sformatf("vec%0d_sat", i), sat_seen, vecs[i].exp_sat);
    end

    // Random operands with input gaps and output backpressure.
    repeat (6) begin
      k   = $urandom_range(1, 16);
      acc = $urandom_range(0, 1);
      sh  = $urandom_range(0, 12);
      for (int kk = 0; kk < k; kk++) begin
        for (int r = 0; r < ROWS; r++) ta[r][kk] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < COLS; c++) tb_m[kk][c] = int'($urandom_range(0, 255)) - 128;
      end
      model_job(k, acc[0]);
      run_job(k, acc[0], sh, 1'b1, 1'b1, sat_seen);
    end

    // Reset asserted while the array is flushing.
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) ta[r][kk] = 1;
      for (int c = 0; c < COLS; c++) tb_m[kk][c] = 1;
    end
    cfg_valid = 1'b1; cfg_k_len = KW'(4); cfg_accumulate = 1'b0; cfg_shift = '0;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) in_a[r*AW +: AW] = AW'(ta[r][kk]);
      for (int c = 0; c < COLS; c++) in_b[c*BW +: BW] = BW'(tb_m[kk][c]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_busy", busy, 1);
    check("flush_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sat_flag", sat_flag, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_row", out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Accumulate onto post-reset state: accumulators must have been cleared.
    for (int r = 0; r < ROWS; r++)
      for (int kk = 0; kk < 4; kk++) ta[r][kk] = (r == kk) ? 1 : 0;
    for (int kk = 0; kk < 4; kk++)
      for (int c = 0; c < COLS; c++) tb_m[kk][c] = kk * 4 + c;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) macc[r][c] = 0;
    model_job(4, 1'b1);
    run_job(4, 1'b1, 0, 1'b0, 1'b0, sat_seen);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) check("post_reset_identity", got[r][c], r * 4 + c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
